// File: rtl/snn_pkg.sv
// Shared types and sizing helpers for the spiking-neuron datapath blocks.
// The neuron block reuses sum_width so both ends agree on accumulator size.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width that holds num * (2^width - 1) without overflow.
  function automatic int sum_width(input int num, input int width);
    return width + $clog2(num);
  endfunction

endpackage

// File: rtl/synapse_accumulator.sv
// Scans the weight store once per start request and sums the weights of every
// synapse that spiked, then offers the total downstream over valid/ready.
module synapse_accumulator
  import snn_pkg::*;
#(
  parameter int NUM_SYNAPSES = 100,
  parameter int WIDTH_P      = 8,
  parameter int ADDR_W       = (NUM_SYNAPSES > 1) ? $clog2(NUM_SYNAPSES) : 1,
  parameter int SUM_W        = sum_width(NUM_SYNAPSES, WIDTH_P)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [NUM_SYNAPSES-1:0] spikes_i,
  output logic                    busy_o,
  output logic                    weight_rd_o,
  output logic [ADDR_W-1:0]       weight_addr_o,
  input  logic [WIDTH_P-1:0]      weight_data_i,
  output logic [SUM_W-1:0]        sum_o,
  output logic                    valid_o,
  input  logic                    ready_i
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SYNAPSES - 1);

  state_e                  state_r;
  logic [NUM_SYNAPSES-1:0] spikes_r;
  logic [SUM_W-1:0]        acc_r;
  logic [ADDR_W-1:0]       addr_r;
  logic                    rd_r;
  logic                    pipe_vld_r;
  logic [ADDR_W-1:0]       pipe_idx_r;
  logic [SUM_W-1:0]        sum_r;
  logic                    valid_r;
  logic                    busy_r;

  logic [SUM_W-1:0]        addend_s;
  logic [SUM_W-1:0]        acc_next_s;
  logic                    last_beat_s;

  // Gate the returning read data with the spike bit of the index it belongs to.
  always_comb begin
    addend_s    = {SUM_W{1'b0}};
    last_beat_s = 1'b0;
    if (pipe_vld_r) begin
      if (spikes_r[pipe_idx_r]) begin
        addend_s = SUM_W'(weight_data_i);
      end else begin
        addend_s = {SUM_W{1'b0}};
      end
      last_beat_s = (pipe_idx_r == LAST_ADDR);
    end else begin
      addend_s    = {SUM_W{1'b0}};
      last_beat_s = 1'b0;
    end
    acc_next_s = acc_r + addend_s;
  end

  // Scan FSM: address counter, one-stage read pipeline and result register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      spikes_r   <= {NUM_SYNAPSES{1'b0}};
      acc_r      <= {SUM_W{1'b0}};
      addr_r     <= {ADDR_W{1'b0}};
      rd_r       <= 1'b0;
      pipe_vld_r <= 1'b0;
      pipe_idx_r <= {ADDR_W{1'b0}};
      sum_r      <= {SUM_W{1'b0}};
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            spikes_r   <= spikes_i;
            acc_r      <= {SUM_W{1'b0}};
            addr_r     <= {ADDR_W{1'b0}};
            rd_r       <= 1'b1;
            pipe_vld_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= SCAN;
          end
        end
        SCAN: begin
          // Data for the address presented this cycle is absorbed next edge.
          pipe_vld_r <= rd_r;
          pipe_idx_r <= addr_r;
          if (rd_r) begin
            if (addr_r == LAST_ADDR) begin
              rd_r <= 1'b0;
            end else begin
              addr_r <= addr_r + ADDR_W'(1);
            end
          end
          acc_r <= acc_next_s;
          if (last_beat_s) begin
            sum_r   <= acc_next_s;
            valid_r <= 1'b1;
            state_r <= DONE;
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          rd_r       <= 1'b0;
          pipe_vld_r <= 1'b0;
          valid_r    <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign busy_o        = busy_r;
  assign weight_rd_o   = rd_r;
  assign weight_addr_o = addr_r;
  assign sum_o         = sum_r;
  assign valid_o       = valid_r;

endmodule

// File: tb/tb_synapse_accumulator.sv
// Self-checking bench for synapse_accumulator with four synapses and a
// latency-1 weight memory; a timeline model is compared every cycle.
module tb_synapse_accumulator;

  localparam int N = 4;
  localparam int W = 8;
  localparam int AW = 2;
  localparam int SW = 10;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [N-1:0]  spikes_i;
  logic          busy_o;
  logic          weight_rd_o;
  logic [AW-1:0] weight_addr_o;
  logic [W-1:0]  weight_data_i;
  logic [SW-1:0] sum_o;
  logic          valid_o;
  logic          ready_i;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  logic [W-1:0] mem [N];

  synapse_accumulator #(.NUM_SYNAPSES(N), .WIDTH_P(W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .spikes_i(spikes_i),
    .busy_o(busy_o), .weight_rd_o(weight_rd_o), .weight_addr_o(weight_addr_o),
    .weight_data_i(weight_data_i), .sum_o(sum_o), .valid_o(valid_o),
    .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Latency-1 weight store; returns junk when no read is issued.
  always @(posedge clk_i) begin
    if (weight_rd_o) weight_data_i <= mem[weight_addr_o];
    else             weight_data_i <= W'($urandom);
  end

  function automatic int ref_sum(input logic [N-1:0] sp);
    int s = 0;
    for (int k = 0; k < N; k++) if (sp[k]) s += int'(mem[k]);
    return s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: phase 0 idle, 1 evaluating (m_t edges since accept), 2 result held.
  int m_phase, m_t, m_exp;
  logic m_valid, m_busy;
  logic [SW-1:0] m_sum;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_phase <= 0; m_t <= 0; m_valid <= 1'b0; m_busy <= 1'b0; m_sum <= '0;
    end else begin
      case (m_phase)
        0: if (start_i) begin
          m_phase <= 1; m_t <= 0; m_busy <= 1'b1; m_exp <= ref_sum(spikes_i);
        end
        1: begin
          m_t <= m_t + 1;
          if (m_t + 1 == N + 1) begin
            m_phase <= 2; m_valid <= 1'b1; m_sum <= SW'(m_exp);
          end
        end
        2: if (ready_i) begin
          m_phase <= 0; m_valid <= 1'b0; m_busy <= 1'b0;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  // Per-cycle comparison away from the active edge.
  always @(negedge clk_i) begin
    if (chk_en) begin
      automatic bit exp_rd = (m_phase == 1) && (m_t < N);
      check("busy", int'(busy_o), int'(m_busy));
      check("valid", int'(valid_o), int'(m_valid));
      check("sum", int'(sum_o), int'(m_sum));
      check("rd", int'(weight_rd_o), int'(exp_rd));
      if (exp_rd) check("addr", int'(weight_addr_o), m_t);
    end
  end

  task automatic run_eval(input logic [N-1:0] sp, input logic [N-1:0] sp_late,
                          output int lat, output int rdc);
    @(negedge clk_i);
    start_i = 1'b1; spikes_i = sp; ready_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0; spikes_i = sp_late;
    lat = 0;
    rdc = weight_rd_o ? 1 : 0;
    while (!valid_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
      if (weight_rd_o) rdc++;
    end
  endtask

  task automatic handshake(input logic st);
    @(negedge clk_i);
    ready_i = 1'b1; start_i = st;
    @(negedge clk_i);
    ready_i = 1'b0; start_i = 1'b0;
  endtask

  int lat, rdc, guard;

  initial begin
    start_i = 1'b0; spikes_i = '0; ready_i = 1'b0; rst_ni = 1'b1;
    mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30; mem[3] = 8'd40;
    #2 rst_ni = 1'b0;
    chk_en = 1'b1;
    #1;
    check("rst_busy", int'(busy_o), 0);
    check("rst_valid", int'(valid_o), 0);
    check("rst_sum", int'(sum_o), 0);
    check("rst_rd", int'(weight_rd_o), 0);
    check("rst_addr", int'(weight_addr_o), 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // Basic sum
    run_eval(4'b0101, 4'b0101, lat, rdc);
    check("basic_lat", lat, 5);
    check("basic_rdcnt", rdc, 4);
    check("basic_sum", int'(sum_o), 40);
    check("basic_model", m_exp, 40);
    handshake(1'b0);

    // Spike vector changes after capture are ignored
    run_eval(4'b0001, 4'b1110, lat, rdc);
    check("capture_sum", int'(sum_o), 10);
    handshake(1'b0);

    // Maximum sum
    for (int k = 0; k < N; k++) mem[k] = 8'd255;
    run_eval(4'b1111, 4'b1111, lat, rdc);
    check("max_sum", int'(sum_o), 1020);
    check("max_lat", lat, 5);
    handshake(1'b0);

    // Zero spikes: full scan, same latency
    run_eval(4'b0000, 4'b0000, lat, rdc);
    check("zero_sum", int'(sum_o), 0);
    check("zero_lat", lat, 5);
    check("zero_rdcnt", rdc, 4);
    handshake(1'b0);

    // Backpressure, ignored starts during DONE and on the handshake edge
    mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30; mem[3] = 8'd40;
    run_eval(4'b1010, 4'b1010, lat, rdc);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      start_i = (i == 2);
      check("bp_sum", int'(sum_o), 60);
      check("bp_valid", int'(valid_o), 1);
    end
    @(negedge clk_i);
    start_i = 1'b1; ready_i = 1'b1;
    @(negedge clk_i);
    check("hs_start_ignored", int'(busy_o), 0);
    ready_i = 1'b0; start_i = 1'b1; spikes_i = 4'b0011;
    @(negedge clk_i);
    start_i = 1'b0;
    check("next_start_taken", int'(busy_o), 1);
    guard = 0;
    while (!valid_o && guard < 20) begin @(negedge clk_i); guard++; end
    check("next_sum", int'(sum_o), 30);
    handshake(1'b0);

    // Reset mid-scan
    @(negedge clk_i);
    start_i = 1'b1; spikes_i = 4'b1111;
    @(negedge clk_i);
    start_i = 1'b0;
    guard = 0;
    while (!(weight_rd_o && weight_addr_o == 2'd2) && guard < 10) begin
      @(negedge clk_i); guard++;
    end
    check("reach_addr2", guard, 2);
    #1 rst_ni = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy_o), 0);
    check("mid_rst_rd", int'(weight_rd_o), 0);
    check("mid_rst_addr", int'(weight_addr_o), 0);
    check("mid_rst_valid", int'(valid_o), 0);
    check("mid_rst_sum", int'(sum_o), 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (6) @(negedge clk_i);
    run_eval(4'b0110, 4'b0110, lat, rdc);
    check("fresh_sum", int'(sum_o), 50);
    check("fresh_lat", lat, 5);
    handshake(1'b0);

    // Randomized evaluations with random backpressure and stray starts
    for (int it = 0; it < 30; it++) begin
      automatic logic [N-1:0] sp = N'($urandom);
      automatic int exp_s;
      for (int k = 0; k < N; k++) mem[k] = W'($urandom);
      exp_s = ref_sum(sp);
      run_eval(sp, N'($urandom), lat, rdc);
      check("rand_lat", lat, 5);
      check("rand_sum", int'(sum_o), exp_s);
      repeat ($urandom_range(0, 4)) begin
        @(negedge clk_i);
        start_i = 1'($urandom);
      end
      handshake(1'($urandom));
    end

    repeat (3) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/synapse_accumulator.md
# synapse_accumulator

Read-side consumer of the synaptic weight store. On a start request it captures a spike vector and scans all `NUM_SYNAPSES` weights through a registered read port. It accumulates the weight of every synapse whose input spiked, then offers the sum to the downstream neuron over a valid/ready handshake. It sits between the weight array (writer) and the neuron membrane update logic.

## Interface
Parameters:
- `NUM_SYNAPSES`, default 100: number of synapses scanned per evaluation; must be ≥1.
- `WIDTH_P`, default 8: unsigned weight width.
- `ADDR_W`, default `$clog2(NUM_SYNAPSES)` (minimum 1): weight address width.
- `SUM_W`, default `WIDTH_P + $clog2(NUM_SYNAPSES)`: accumulator width; sized so the sum can never overflow.

Ports:
- `clk_i`, input, 1: single clock; all state updates on the rising edge.
- `rst_ni`, input, 1: reset, asynchronous and active-low.
- `start_i`, input, 1: evaluation request; sampled only in IDLE.
- `spikes_i`, input, NUM_SYNAPSES: spike vector; bit k gates synapse k; captured on the edge that accepts start.
- `busy_o`, output, 1: high in SCAN and DONE.
- `weight_rd_o`, output, 1: read strobe, high while an address is presented.
- `weight_addr_o`, output, ADDR_W: synapse index being read.
- `weight_data_i`, input, WIDTH_P: read data, valid the cycle after its address is presented (fixed latency 1).
- `sum_o`, output, SUM_W: accumulated weighted input; held stable while `valid_o` is high.
- `valid_o`, output, 1: result available.
- `ready_i`, input, 1: downstream accepts the result.

## Operation
- States: IDLE, SCAN, DONE.
- **IDLE → SCAN** when `start_i`=1:
  - capture `spikes_i`;
  - clear the accumulator;
  - set `weight_addr_o`=0 and `weight_rd_o`=1.
- **SCAN**:
  - Each cycle, advance the address by 1 until it reaches NUM_SYNAPSES-1, then drop `weight_rd_o`.
  - One cycle behind the address, add `weight_data_i` (zero-extended to SUM_W) to the accumulator if the captured spike bit for that delayed index is 1.
  - A one-bit delayed-valid and a delayed index track this pipeline.
- **SCAN → DONE** on the edge that absorbs the data for index NUM_SYNAPSES-1. The final sum is registered to `sum_o` and `valid_o` is set.
- **DONE → IDLE** on an edge with `ready_i`=1. `valid_o` clears; `sum_o` holds its last value.
- `start_i` is ignored in SCAN and DONE. It is not queued. A `start_i` in the same cycle as the DONE handshake is ignored.
- All-zero spikes still perform the full scan, so latency is constant. The result is `sum_o`=0.
- The address never wraps. No reads are issued beyond NUM_SYNAPSES-1.
- Changes on `spikes_i` after capture have no effect.
- Arithmetic is unsigned with no saturation. The maximum sum is NUM_SYNAPSES·(2^WIDTH_P−1), which fits in SUM_W.

## Timing
- Reset (asynchronous, any state, including mid-scan):
  - state=IDLE;
  - `busy_o`=0, `weight_rd_o`=0, `weight_addr_o`=0, `valid_o`=0, `sum_o`=0;
  - accumulator, captured spikes and pipeline valid cleared.
  - The partial result is discarded and no `valid_o` pulse occurs.
- Edge E0 accepts start.
- Address k is presented during cycle k (E_k to E_k+1). Its data is summed at E_k+2.
- The last address NUM_SYNAPSES-1 is presented in cycle NUM_SYNAPSES-1.
- `valid_o` rises at E_(NUM_SYNAPSES+1), i.e. NUM_SYNAPSES+1 edges after the accepting edge.
- `weight_rd_o` is high for exactly NUM_SYNAPSES cycles per evaluation.
- `valid_o` stays high until the handshake edge. The earliest next start is the cycle after the handshake.
- Minimum period per evaluation: NUM_SYNAPSES+3 cycles with `ready_i` tied high.

## Structure
- Shared package `snn_pkg` holds:
  - the state enum (IDLE/SCAN/DONE);
  - a `sum_width(num, width)` constant function reused by the neuron block.
- No sub-module is needed. The address counter, one-stage read pipeline and FSM live in one module, roughly 150–250 lines.

## Test plan
Configuration: NUM_SYNAPSES=4, WIDTH_P=8, with a bench memory of latency 1.
- **Basic sum:** weights {10,20,30,40}, spikes=4'b0101, start → `valid_o` rises 5 edges after the accepting edge with `sum_o`=40; `weight_rd_o` high 4 cycles, addresses 0,1,2,3.
- **Maximum sum:** weights all 255, spikes=4'b1111 → `sum_o`=1020, no overflow in 10 bits.
- **Zero spikes:** spikes=0 → full 4-read scan, `sum_o`=0, same latency.
- **Backpressure:** hold `ready_i`=0 for 6 cycles → `valid_o` and `sum_o` stable; a `start_i` pulse during DONE and on the handshake edge is ignored; a start one cycle after the handshake is accepted.
- **Reset mid-scan:** assert `rst_ni`=0 while address=2 → all outputs 0 immediately, no `valid_o`; a new start after release yields a correct fresh sum.
- **Spike capture:** toggle `spikes_i` from 4'b0001 to 4'b1110 one cycle after start, with weights {10,20,30,40} → `sum_o`=10.
